// File: rtl/apb_multi_slave_subsys.sv
// APB subsystem: one command-driven APB master, NUM_SLV register-bank slaves
// with configurable wait states, an address decoder and a default error
// responder for addresses that hit no slave.
//
// Handshake: a command is accepted when cmd_i[0]=1 (READ/WRITE) and busy_o=0;
// there is no backpressure queue, so commands seen while busy_o=1 are dropped.
// Inside, the APB transfer completes on the ACCESS cycle where the selected
// pready is 1. done_o pulses for one cycle after that, with err_o and rdata_o.
module apb_multi_slave_subsys #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int NUM_SLV   = 4,
    parameter int SLV_DEPTH = 16,
    parameter int WAIT_CYC  = 0
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic [1:0]          cmd_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] strb_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                ready_o,
    output logic [NUM_SLV-1:0]  psel_o,
    output logic                penable_o,
    output logic [1:0]          state_o
);

    localparam int STRB_W    = DATA_W / 8;
    localparam int WORD_BITS = $clog2(SLV_DEPTH);
    localparam int SLV_BITS  = $clog2(NUM_SLV);
    localparam int SLV_SHIFT = 2 + WORD_BITS;
    localparam int TOP_SHIFT = SLV_SHIFT + SLV_BITS;
    localparam logic [ADDR_W-1:0] SLV_MASK  = ADDR_W'((1 << SLV_BITS) - 1);
    localparam logic [ADDR_W-1:0] NUM_SLV_A = ADDR_W'(NUM_SLV);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   strb_q;
    logic                write_q;
    logic                done_q;
    logic                err_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   mem_q  [NUM_SLV][SLV_DEPTH];
    logic [2:0]          wait_q [NUM_SLV];

    logic [ADDR_W-1:0]    slv_num;
    logic [ADDR_W-1:0]    upper_bits;
    logic [WORD_BITS-1:0] word_idx;
    logic                 dec_err;
    logic [NUM_SLV-1:0]   psel;
    logic [NUM_SLV-1:0]   pready_s;
    logic                 sel_ready;
    logic [DATA_W-1:0]    rd_word;
    logic                 complete;

    // Address split of the captured transfer; any stray bit is a decode error.
    assign slv_num    = (addr_q >> SLV_SHIFT) & SLV_MASK;
    assign upper_bits = addr_q >> TOP_SHIFT;
    assign word_idx   = addr_q[2 +: WORD_BITS];
    assign dec_err    = (addr_q[1:0] != 2'b00) || (upper_bits != '0) ||
                        (slv_num >= NUM_SLV_A);

    // Each slave raises pready once it has held it low for WAIT_CYC cycles.
    always_comb begin
        for (int i = 0; i < NUM_SLV; i++) begin
            pready_s[i] = (wait_q[i] == 3'(WAIT_CYC));
        end
    end

    // Slave select, pready/rdata mux; the default responder answers at once.
    always_comb begin
        psel      = '0;
        sel_ready = 1'b0;
        rd_word   = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (state_q != IDLE && !dec_err && slv_num == ADDR_W'(i)) begin
                psel[i]   = 1'b1;
                sel_ready = pready_s[i];
                rd_word   = mem_q[i][word_idx];
            end
        end
        if (dec_err) begin
            sel_ready = 1'b1;
        end
    end

    assign complete = (state_q == ACCESS) && sel_ready;

    // FSM state register.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: IDLE -> SETUP on READ/WRITE, SETUP -> ACCESS, ACCESS -> IDLE on pready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_i[0]) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (sel_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the command only when idle so commands during a transfer are dropped.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            write_q <= 1'b0;
        end else if (state_q == IDLE && cmd_i[0]) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            strb_q  <= strb_i;
            write_q <= cmd_i[1];
        end
    end

    // Completion status registers: one-cycle done, sticky err, last read data.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            done_q <= complete;
            if (complete) begin
                err_q <= dec_err;
                if (!write_q) begin
                    rdata_q <= dec_err ? '0 : rd_word;
                end
            end
        end
    end

    // Per-slave wait-state counters, cleared whenever the slave is not stalling.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < NUM_SLV; i++) wait_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SLV; i++) begin
                if (psel[i] && state_q == ACCESS && !pready_s[i]) begin
                    wait_q[i] <= wait_q[i] + 3'd1;
                end else begin
                    wait_q[i] <= '0;
                end
            end
        end
    end

    // Register banks: strobed byte-lane writes on the completing cycle only.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < NUM_SLV; i++) begin
                for (int j = 0; j < SLV_DEPTH; j++) mem_q[i][j] <= '0;
            end
        end else if (complete && write_q && !dec_err) begin
            for (int i = 0; i < NUM_SLV; i++) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (psel[i] && strb_q[b]) begin
                        mem_q[i][word_idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
                    end
                end
            end
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign penable_o = (state_q == ACCESS);
    assign ready_o   = (state_q == ACCESS) && sel_ready;
    assign psel_o    = psel;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign rdata_o   = rdata_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_apb_multi_slave_subsys.sv
// Bench for apb_multi_slave_subsys: dut0 uses defaults (4 slaves, no waits),
// dut1 has 3 slaves and 3 wait states. Drivers push expected {err, rdata}
// into per-instance queues; monitors pop and compare on every done_o pulse.
module tb_apb_multi_slave_subsys;

    logic             pclk;
    logic [1:0]       rst;
    logic [1:0][1:0]  cmd;
    logic [1:0][7:0]  addr;
    logic [1:0][31:0] wdata;
    logic [1:0][3:0]  strb;
    logic [1:0]       busy, done, err, ready, penable;
    logic [1:0][31:0] rdata;
    logic [1:0][3:0]  psel;
    logic [1:0][1:0]  st;

    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    logic [31:0] last_rd [2];
    int          done_cnt [2];
    int          n_checks;
    int          n_errors;

    apb_multi_slave_subsys #(.ADDR_W(8), .DATA_W(32), .NUM_SLV(4), .SLV_DEPTH(16), .WAIT_CYC(0)) dut0 (
        .pclk(pclk), .preset(rst[0]), .cmd_i(cmd[0]), .addr_i(addr[0]), .wdata_i(wdata[0]),
        .strb_i(strb[0]), .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0]), .rdata_o(rdata[0]),
        .ready_o(ready[0]), .psel_o(psel[0]), .penable_o(penable[0]), .state_o(st[0])
    );

    apb_multi_slave_subsys #(.ADDR_W(8), .DATA_W(32), .NUM_SLV(3), .SLV_DEPTH(16), .WAIT_CYC(3)) dut1 (
        .pclk(pclk), .preset(rst[1]), .cmd_i(cmd[1]), .addr_i(addr[1]), .wdata_i(wdata[1]),
        .strb_i(strb[1]), .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1]), .rdata_o(rdata[1]),
        .ready_o(ready[1]), .psel_o(psel[1][2:0]), .penable_o(penable[1]), .state_o(st[1])
    );
    assign psel[1][3] = 1'b0;

    // Clock
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_idle(input int d, input string tag);
        chk({tag, "_ctl"}, 64'({busy[d], done[d], err[d], ready[d], penable[d], st[d], psel[d]}), 64'd0);
        chk({tag, "_rdata"}, 64'(rdata[d]), 64'd0);
    endtask

    // Monitor: every done_o pulse consumes one expected response.
    always @(negedge pclk) begin
        logic [32:0] e;
        bit have;
        for (int d = 0; d < 2; d++) begin
            if (done[d] === 1'b1) begin
                done_cnt[d]++;
                have = 1'b0;
                e = '0;
                if (d == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
                if (d == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
                if (!have) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL dut%0d_unexpected_done: actual=1 required=0", d);
                end else begin
                    chk($sformatf("dut%0d_err", d), 64'(err[d]), 64'(e[32]));
                    chk($sformatf("dut%0d_rdata", d), 64'(rdata[d]), 64'(e[31:0]));
                end
            end
        end
    end

    // Driver: issue one command, push its expected response, time the transfer.
    task automatic xfer(input int d, input logic [1:0] c, input logic [7:0] a,
                        input logic [31:0] wd, input logic [3:0] sb,
                        input logic e_err, input logic [31:0] e_rd,
                        input int e_lat, input int e_low, input logic [3:0] e_psel,
                        input bit inject);
        int lat, low;
        bit got;
        logic [3:0] ps;
        logic [32:0] ex;
        if (c == 2'b11) begin
            ex = {e_err, last_rd[d]};
        end else begin
            ex = {e_err, e_rd};
            last_rd[d] = e_rd;
        end
        if (d == 0) exp_q0.push_back(ex);
        else exp_q1.push_back(ex);
        cmd[d] = c; addr[d] = a; wdata[d] = wd; strb[d] = sb;
        lat = 0; low = 0; got = 1'b0; ps = '0;
        while (!got && lat < 40) begin
            @(posedge pclk);
            lat++;
            @(negedge pclk);
            if (lat == 1) begin
                cmd[d] = 2'b00;
                ps = psel[d];
            end
            if (inject && lat == 2) begin
                chk("busy_at_inject", 64'(busy[d]), 64'd1);
                cmd[d] = 2'b11; addr[d] = 8'h08; wdata[d] = 32'hFFFF_FFFF; strb[d] = 4'hF;
            end
            if (inject && lat == 3) cmd[d] = 2'b00;
            if (penable[d] && !ready[d]) low++;
            if (done[d]) got = 1'b1;
        end
        chk($sformatf("dut%0d_done_seen_%02h", d, a), 64'(got), 64'd1);
        chk($sformatf("dut%0d_latency_%02h", d, a), 64'(lat), 64'(e_lat));
        chk($sformatf("dut%0d_ready_low_%02h", d, a), 64'(low), 64'(e_low));
        chk($sformatf("dut%0d_psel_%02h", d, a), 64'(ps), 64'(e_psel));
    endtask

    localparam logic [1:0] RD = 2'b01;
    localparam logic [1:0] WR = 2'b11;

    initial begin
        int dc;
        n_checks = 0; n_errors = 0;
        done_cnt[0] = 0; done_cnt[1] = 0;
        last_rd[0] = '0; last_rd[1] = '0;
        rst = 2'b11; cmd = '0; addr = '0; wdata = '0; strb = '0;
        repeat (2) @(negedge pclk);
        chk_idle(0, "dut0_reset");
        chk_idle(1, "dut1_reset");
        rst = 2'b00;
        @(negedge pclk);

        // dut0: full write/read, partial strobes, misaligned read
        xfer(0, WR, 8'h94, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, 3, 0, 4'b0100, 1'b0);
        xfer(0, RD, 8'h94, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF, 3, 0, 4'b0100, 1'b0);
        xfer(0, WR, 8'h94, 32'h1122_3344, 4'h5, 1'b0, 32'h0, 3, 0, 4'b0100, 1'b0);
        xfer(0, RD, 8'h94, 32'h0, 4'h0, 1'b0, 32'hDE22_BE44, 3, 0, 4'b0100, 1'b0);
        xfer(0, RD, 8'h95, 32'h0, 4'h0, 1'b1, 32'h0, 3, 0, 4'b0000, 1'b0);
        repeat (2) @(negedge pclk);
        chk("dut0_err_sticky", 64'(err[0]), 64'd1);
        chk("dut0_idle_after_err", 64'({busy[0], penable[0], psel[0]}), 64'd0);

        // dut0: back-to-back write then read issued in the done cycle; top word
        xfer(0, WR, 8'h00, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'h0, 3, 0, 4'b0001, 1'b0);
        xfer(0, RD, 8'h00, 32'h0, 4'h0, 1'b0, 32'hA5A5_A5A5, 3, 0, 4'b0001, 1'b0);
        xfer(0, WR, 8'hFC, 32'h0BAD_F00D, 4'hF, 1'b0, 32'h0, 3, 0, 4'b1000, 1'b0);
        xfer(0, RD, 8'hFC, 32'h0, 4'h0, 1'b0, 32'h0BAD_F00D, 3, 0, 4'b1000, 1'b0);

        // dut1: wait states, out-of-range slave, command during busy
        xfer(1, WR, 8'h00, 32'h55AA_55AA, 4'hF, 1'b0, 32'h0, 6, 3, 4'b0001, 1'b0);
        xfer(1, WR, 8'hC0, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0, 3, 0, 4'b0000, 1'b0);
        xfer(1, RD, 8'h04, 32'h0, 4'h0, 1'b0, 32'h0, 6, 3, 4'b0001, 1'b1);
        xfer(1, RD, 8'h08, 32'h0, 4'h0, 1'b0, 32'h0, 6, 3, 4'b0001, 1'b0);
        xfer(1, RD, 8'h00, 32'h0, 4'h0, 1'b0, 32'h55AA_55AA, 6, 3, 4'b0001, 1'b0);
        xfer(1, RD, 8'h40, 32'h0, 4'h0, 1'b0, 32'h0, 6, 3, 4'b0010, 1'b0);
        xfer(1, RD, 8'h80, 32'h0, 4'h0, 1'b0, 32'h0, 6, 3, 4'b0100, 1'b0);

        // dut0: reset in the middle of ACCESS
        @(negedge pclk);
        cmd[0] = WR; addr[0] = 8'h10; wdata[0] = 32'h1234_5678; strb[0] = 4'hF;
        @(posedge pclk);
        @(negedge pclk);
        cmd[0] = 2'b00;
        @(posedge pclk);
        @(negedge pclk);
        chk("dut0_pre_rst_penable", 64'(penable[0]), 64'd1);
        dc = done_cnt[0];
        #1 rst[0] = 1'b1;
        #1 chk_idle(0, "dut0_async_rst");
        @(posedge pclk);
        @(negedge pclk);
        rst[0] = 1'b0;
        last_rd[0] = '0;
        repeat (4) @(negedge pclk);
        chk("dut0_no_done_after_rst", 64'(done_cnt[0] - dc), 64'd0);
        chk("dut0_state_after_rst", 64'(st[0]), 64'd0);
        xfer(0, RD, 8'h94, 32'h0, 4'h0, 1'b0, 32'h0, 3, 0, 4'b0100, 1'b0);
        xfer(0, RD, 8'h00, 32'h0, 4'h0, 1'b0, 32'h0, 3, 0, 4'b0001, 1'b0);
        xfer(0, RD, 8'hFC, 32'h0, 4'h0, 1'b0, 32'h0, 3, 0, 4'b1000, 1'b0);
        xfer(0, RD, 8'h10, 32'h0, 4'h0, 1'b0, 32'h0, 3, 0, 4'b0001, 1'b0);

        repeat (3) @(negedge pclk);
        chk("dut0_queue_empty", 64'(exp_q0.size()), 64'd0);
        chk("dut1_queue_empty", 64'(exp_q1.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
